// File: rtl/uart_pkg.sv
// Shared UART scheduler types and transmitter timing constants.
// Both the scheduler and the transmitter bench model draw on these.
package uart_pkg;

    localparam int ClkFrequency = 27000000;
    localparam int Baud = 115200;
    localparam int BitClocks = ClkFrequency / Baud;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_ACK,
        WAIT_DONE,
        FETCH,
        GAP
    } sched_state_t;

    function automatic int wrapInc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/uart_tx_scheduler_rr_arbiter.sv
// Round-robin pick: first requester at or after rrPtr, wrapping.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rrPtr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    grantId
);

    logic found;
    int   idx;

    always_comb begin
        grant   = '0;
        grantId = '0;
        found   = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            idx = int'(rrPtr) + off;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grantId    = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between NUM_REQ packet requesters,
// round-robin per packet, sequencing the start/busy handshake.
module uart_tx_scheduler
    import uart_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W = 2,
    parameter int GAP_CYCLES = 16,
    parameter int FETCH_TIMEOUT = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic                 abort
);

    localparam int GapW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam int GapMax = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
    localparam int ToW = $clog2(FETCH_TIMEOUT + 1);
    localparam sched_state_t AfterPkt = (GAP_CYCLES > 0) ? GAP : IDLE;

    sched_state_t      state;
    logic              lastR;
    logic [ID_W-1:0]   rrPtr;
    logic [GapW-1:0]   gapCnt;
    logic [ToW-1:0]    toCnt;

    logic [NUM_REQ-1:0] arbGrant;
    logic [ID_W-1:0]    arbId;
    logic [NUM_REQ-1:0] ownMask;
    logic [ID_W-1:0]    selIdx;
    logic [7:0]         selData;
    logic               selLast;
    logic               xfer;
    logic [ID_W-1:0]    nextPtr;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) uArb (
        .req    (req_valid),
        .rrPtr  (rrPtr),
        .grant  (arbGrant),
        .grantId(arbId)
    );

    assign ownMask = NUM_REQ'(1) << grant_id;
    assign nextPtr = ID_W'(wrapInc(int'(grant_id), NUM_REQ));

    // Only IDLE (transmitter free) and FETCH may accept a byte.
    always_comb begin
        req_ready = '0;
        if (!rst) begin
            unique case (state)
                IDLE:    req_ready = tx_busy ? '0 : arbGrant;
                FETCH:   req_ready = req_valid & ownMask;
                default: req_ready = '0;
            endcase
        end
    end

    always_comb begin
        selIdx  = (state == IDLE) ? arbId : grant_id;
        selData = req_data[8*selIdx +: 8];
        selLast = req_last[selIdx];
        xfer    = |req_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lastR    <= 1'b0;
            rrPtr    <= '0;
            gapCnt   <= '0;
            toCnt    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
            grant_id <= '0;
            active   <= 1'b0;
            abort    <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            abort    <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (xfer) begin
                        tx_data  <= selData;
                        lastR    <= selLast;
                        grant_id <= arbId;
                        active   <= 1'b1;
                        tx_start <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    state <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (lastR) begin
                            rrPtr  <= nextPtr;
                            active <= 1'b0;
                            gapCnt <= '0;
                            state  <= AfterPkt;
                        end else begin
                            toCnt <= '0;
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (xfer) begin
                        tx_data  <= selData;
                        lastR    <= selLast;
                        tx_start <= 1'b1;
                        state    <= START;
                    end else if (toCnt == ToW'(FETCH_TIMEOUT - 1)) begin
                        abort  <= 1'b1;
                        active <= 1'b0;
                        rrPtr  <= nextPtr;
                        gapCnt <= '0;
                        state  <= AfterPkt;
                    end else begin
                        toCnt <= toCnt + 1'b1;
                    end
                end
                GAP: begin
                    if (gapCnt == GapW'(GapMax)) begin
                        state <= IDLE;
                    end else begin
                        gapCnt <= gapCnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
